// File: rtl/uart_tx_fsm.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : uart_tx_fsm                                                |
// | Description : UART transmitter. Sends 1 start bit, DATA_WIDTH data bits  |
// |               LSB first, an optional parity bit and 1 stop bit on TX_OUT.|
// |               Frame settings are captured when DATA_VALID is accepted.   |
// | Options     : `define UART_TX_BACK2BACK_EN drops BUSY during the final   |
// |               stop-bit cycle and accepts the next frame in that cycle,   |
// |               so consecutive frames need no idle cycle between them.     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module uart_tx_fsm #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [PRESCALE_W-1:0] PRESCALE,
  output logic                  TX_OUT,
  output logic                  BUSY
);

  // Bit counter only has to reach DATA_WIDTH-1.
  localparam int c_bcnt_w = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [c_bcnt_w-1:0] c_bit_last = c_bcnt_w'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;

  // Prescale counter and the latched last count (P-1, with P=0 handled as 1).
  logic [PRESCALE_W-1:0] r_pre_cnt;
  logic [PRESCALE_W-1:0] w_pre_cnt_nxt;
  logic [PRESCALE_W-1:0] r_pre_last;
  logic [PRESCALE_W-1:0] w_pre_last_nxt;

  logic [c_bcnt_w-1:0]   r_bit_cnt;
  logic [c_bcnt_w-1:0]   w_bit_cnt_nxt;

  logic [DATA_WIDTH-1:0] r_shreg;
  logic [DATA_WIDTH-1:0] w_shreg_nxt;

  logic                  r_par_en;
  logic                  w_par_en_nxt;
  logic                  r_par_bit;
  logic                  w_par_bit_nxt;

  logic                  r_tx;
  logic                  w_tx_nxt;
  logic                  r_busy;
  logic                  w_busy_nxt;

  logic                  w_bit_done;
  logic                  w_accept;

  // The current bit period ends on the cycle the counter sits at P-1.
  assign w_bit_done = (r_pre_cnt == r_pre_last);

  // Next-state, datapath and registered-output decode.
  always_comb begin
    w_state_nxt    = r_state;
    w_pre_cnt_nxt  = '0;
    w_pre_last_nxt = r_pre_last;
    w_bit_cnt_nxt  = r_bit_cnt;
    w_shreg_nxt    = r_shreg;
    w_par_en_nxt   = r_par_en;
    w_par_bit_nxt  = r_par_bit;
    w_accept       = 1'b0;
    w_tx_nxt       = 1'b1;
    w_busy_nxt     = 1'b0;

    case (r_state)
      IDLE: begin
        w_bit_cnt_nxt = '0;
        if (DATA_VALID) begin
          w_accept = 1'b1;
        end
      end

      START: begin
        w_pre_cnt_nxt = w_bit_done ? '0 : r_pre_cnt + 1'b1;
        if (w_bit_done) begin
          w_state_nxt = DATA;
        end
      end

      DATA: begin
        w_pre_cnt_nxt = w_bit_done ? '0 : r_pre_cnt + 1'b1;
        if (w_bit_done) begin
          w_shreg_nxt = r_shreg >> 1;
          if (r_bit_cnt == c_bit_last) begin
            w_bit_cnt_nxt = '0;
            w_state_nxt   = r_par_en ? PARITY : STOP;
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + 1'b1;
          end
        end
      end

      PARITY: begin
        w_pre_cnt_nxt = w_bit_done ? '0 : r_pre_cnt + 1'b1;
        if (w_bit_done) begin
          w_state_nxt = STOP;
        end
      end

      STOP: begin
        w_pre_cnt_nxt = w_bit_done ? '0 : r_pre_cnt + 1'b1;
        if (w_bit_done) begin
`ifdef UART_TX_BACK2BACK_EN
          // Final stop cycle: a waiting request chains straight into START.
          if (DATA_VALID) begin
            w_accept = 1'b1;
          end else begin
            w_state_nxt = IDLE;
          end
`else
          w_state_nxt = IDLE;
`endif
        end
      end

      default: begin
        // Unreachable encodings fall back to a clean idle line.
        w_state_nxt   = IDLE;
        w_bit_cnt_nxt = '0;
      end
    endcase

    // Capture the whole frame configuration so later input changes are inert.
    if (w_accept) begin
      w_state_nxt    = START;
      w_pre_cnt_nxt  = '0;
      w_bit_cnt_nxt  = '0;
      w_shreg_nxt    = P_DATA;
      w_pre_last_nxt = (PRESCALE == '0) ? '0 : PRESCALE - 1'b1;
      w_par_en_nxt   = PAR_EN;
      w_par_bit_nxt  = (^P_DATA) ^ PAR_TYP;
    end

    // Line level and BUSY follow the state being entered, giving
    // registered outputs that line up with the state register.
    case (w_state_nxt)
      IDLE: begin
        w_tx_nxt   = 1'b1;
        w_busy_nxt = 1'b0;
      end
      START: begin
        w_tx_nxt   = 1'b0;
        w_busy_nxt = 1'b1;
      end
      DATA: begin
        w_tx_nxt   = w_shreg_nxt[0];
        w_busy_nxt = 1'b1;
      end
      PARITY: begin
        w_tx_nxt   = w_par_bit_nxt;
        w_busy_nxt = 1'b1;
      end
      STOP: begin
        w_tx_nxt   = 1'b1;
        w_busy_nxt = 1'b1;
      end
      default: begin
        w_tx_nxt   = 1'b1;
        w_busy_nxt = 1'b0;
      end
    endcase

`ifdef UART_TX_BACK2BACK_EN
    // Advertise readiness during the last stop-bit cycle.
    if ((w_state_nxt == STOP) && (w_pre_cnt_nxt == w_pre_last_nxt)) begin
      w_busy_nxt = 1'b0;
    end
`endif
  end

  // State, counters, datapath and output registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_state    <= IDLE;
      r_pre_cnt  <= '0;
      r_pre_last <= '0;
      r_bit_cnt  <= '0;
      r_shreg    <= '0;
      r_par_en   <= 1'b0;
      r_par_bit  <= 1'b0;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pre_cnt  <= w_pre_cnt_nxt;
      r_pre_last <= w_pre_last_nxt;
      r_bit_cnt  <= w_bit_cnt_nxt;
      r_shreg    <= w_shreg_nxt;
      r_par_en   <= w_par_en_nxt;
      r_par_bit  <= w_par_bit_nxt;
      r_tx       <= w_tx_nxt;
      r_busy     <= w_busy_nxt;
    end
  end

  assign TX_OUT = r_tx;
  assign BUSY   = r_busy;

endmodule
`default_nettype wire

// File: doc/uart_tx_fsm.md
Name: uart_tx_fsm

Overview:
- UART transmitter, transmit-side counterpart of the UART receive path; uses the same frame format.
- Frame: 1 start bit (0), DATA_WIDTH data bits LSB first, optional parity bit, 1 stop bit (1).
- Contains a control FSM, a bit-period prescale counter, a bit counter, a parity generator and a shift register.
- Sits between the system-side data producer (valid/busy handshake) and the serial line TX_OUT.

Parameters:
- DATA_WIDTH, 8, data bits per frame.
- PRESCALE_W, 6, width of the PRESCALE input (clock cycles per bit).

Ports:
- CLK  input  1  system clock; all logic on rising edge.
- RST  input  1  synchronous, active-low reset.
- P_DATA  input  DATA_WIDTH  parallel data to send.
- DATA_VALID  input  1  request to send P_DATA.
- PAR_EN  input  1  1 = append parity bit.
- PAR_TYP  input  1  0 = even parity, 1 = odd parity.
- PRESCALE  input  PRESCALE_W  clock cycles per bit; value 0 is treated as 1.
- TX_OUT  output  1  serial line, registered; idles high.
- BUSY  output  1  registered; high while a frame is in progress.

Behaviour:
- Reset: synchronous; takes effect at the CLK edge where RST=0. After that edge: TX_OUT=1, BUSY=0, state=IDLE, all counters=0.
- Reset asserted mid-frame aborts the frame. The line returns high at the next edge; no partial stop bit is sent.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - TX_OUT=1, BUSY=0.
  - If DATA_VALID=1 at edge n: latch P_DATA, PAR_EN, PAR_TYP and PRESCALE; compute the parity bit from the latched data; go to START.
  - Parity bit = XOR of all data bits when PAR_TYP=0; the inverse of that XOR when PAR_TYP=1.
  - After edge n: TX_OUT=0 and BUSY=1, i.e. one-cycle latency from DATA_VALID to the start bit.
- Bit timing:
  - Each bit is held for exactly max(PRESCALE,1) cycles.
  - The prescale counter counts 0..P-1; the bit advances when the counter reaches P-1, and the counter wraps to 0.
- START: TX_OUT=0 for one bit period, then go to DATA.
- DATA:
  - TX_OUT = shift-register LSB; shift right on each bit advance.
  - The bit counter counts 0..DATA_WIDTH-1.
  - After bit DATA_WIDTH-1: go to PARITY if latched PAR_EN=1, else go to STOP.
- PARITY: TX_OUT = latched parity bit for one bit period, then go to STOP.
- STOP:
  - TX_OUT=1 for one bit period, then go to IDLE. BUSY falls at the same edge.
  - IDLE lasts at least 1 cycle before the next start bit (line high).
- Frame length in cycles: P*(DATA_WIDTH+2), plus P when parity is enabled.
- DATA_VALID while BUSY=1 is ignored; nothing is queued.
- P_DATA, PAR_EN, PAR_TYP and PRESCALE changing mid-frame have no effect, because they are latched at frame start.
- Illegal state encodings recover to IDLE at the next edge, with TX_OUT=1.

Optional Feature:
- Macro: UART_TX_BACK2BACK_EN
- Defined:
  - BUSY deasserts combinationally-registered one cycle early: it is low during the final cycle of the stop bit.
  - DATA_VALID=1 in that cycle latches the new data and goes directly to START. The next start bit follows the stop bit with no idle cycle.
  - DATA_VALID=0 in that cycle goes to IDLE as normal.
- Not defined: behaviour exactly as described in Behaviour above; there is always at least one idle-high cycle between frames.

Test Plan:
- Reset and idle: RST=0 for 2 cycles, then RST=1 with no DATA_VALID -> TX_OUT=1 and BUSY=0 on every cycle.
- No parity:
  - Stimulus: PRESCALE=4, PAR_EN=0, P_DATA=0xA5, one-cycle DATA_VALID.
  - Response: TX_OUT low 1 cycle later. Line sequence 0,1,0,1,0,0,1,0,1,1, each bit for 4 cycles. BUSY high for exactly 40 cycles.
- Parity:
  - Stimulus: PRESCALE=4, PAR_EN=1, P_DATA=0xA5.
  - PAR_TYP=0 -> parity bit 0. PAR_TYP=1 -> parity bit 1. BUSY high for 44 cycles.
  - Repeat with P_DATA=0x01 -> even parity bit 1, odd parity bit 0.
- Busy and corner cases:
  - DATA_VALID pulsed with 0x3C during the DATA state of a frame carrying 0xA5 -> 0x3C is never sent; the 0xA5 frame is intact.
  - PRESCALE=0 -> each bit lasts 1 cycle; a no-parity frame takes 10 cycles.
- Reset mid-frame: RST=0 during DATA bit 3 -> TX_OUT=1 and BUSY=0 after that edge. A new DATA_VALID then produces a complete, correct frame.
- Back-to-back: with UART_TX_BACK2BACK_EN, DATA_VALID held high with 0x55 then 0xAA -> the second start bit immediately follows the first stop bit (0 idle cycles). Without the macro -> exactly 1 idle-high cycle between the frames.
